ptp_rtc_adjuster: RTL and testbench

Control-side driver for the real time counter's adjustment interface. It owns the counter's tick increment, offset/valid, and clear inputs.
- Accepts software/servo requests of four kinds: step offset, set absolute time, clear, and set tick increment.
- Converts each request into correctly ranged, correctly timed pulses for the counter.
- Enforces a guard interval so consecutive adjustments never collide with the counter's wrap-around retention window.

---
 rtl/ptp_rtc_adjuster_pkg.sv | 31 +++
 rtl/ptp_offset_norm.sv | 26 ++
 rtl/ptp_rtc_adjuster.sv | 170 +++++++++++++++++
 tb/tb_ptp_rtc_adjuster.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptp_rtc_adjuster_pkg.sv
// Shared constants, request encoding and helpers for the RTC adjustment driver.
package ptp_rtc_adjuster_pkg;

  localparam int unsigned NSC_W = 48;
  localparam int unsigned FNS_W = 32;
  localparam logic [31:0] SC2NS = 32'd1_000_000_000;

  localparam logic [1:0] REQ_STEP  = 2'd0;
  localparam logic [1:0] REQ_SET   = 2'd1;
  localparam logic [1:0] REQ_CLEAR = 2'd2;
  localparam logic [1:0] REQ_TICK  = 2'd3;

  typedef struct packed {
    logic [1:0]       kind;
    logic [NSC_W-1:0] sc;
    logic [FNS_W-1:0] ns;
  } adj_req_t;

  // Absolute-set ns is unsigned, step ns is a signed offset; both must stay below one second.
  function automatic logic ns_out_of_range(input logic [1:0] kind, input logic [31:0] ns);
    logic res;
    res = 1'b0;
    if (kind == REQ_SET) begin
      res = (ns >= SC2NS);
    end else if (kind == REQ_STEP) begin
      res = ($signed(ns) >= $signed(SC2NS)) || ($signed(ns) <= -$signed(SC2NS));
    end
    return res;
  endfunction

endpackage

// File: rtl/ptp_offset_norm.sv
// Single-step +/-1 s normaliser folding an out-of-range ns offset into the seconds field.
module ptp_offset_norm
  import ptp_rtc_adjuster_pkg::*;
(
  input  logic [33:0] ns_d,
  input  logic [47:0] sc_d,
  output logic [31:0] ns_o,
  output logic [47:0] sc_o
);

  localparam logic signed [33:0] NsLim = $signed({2'b00, SC2NS});

  // Low 32 bits of the adjusted value are the same whether computed at 34 or 32 bits.
  always_comb begin
    ns_o = ns_d[31:0];
    sc_o = sc_d;
    if ($signed(ns_d) <= -NsLim) begin
      ns_o = ns_d[31:0] + SC2NS;
      sc_o = sc_d - 48'd1;
    end else if ($signed(ns_d) >= NsLim) begin
      ns_o = ns_d[31:0] - SC2NS;
      sc_o = sc_d + 48'd1;
    end
  end

endmodule

// File: rtl/ptp_rtc_adjuster.sv
// Drives the real time counter's tick increment, offset and clear inputs from servo requests,
// holding a guard window after every pulse so adjustments never overlap the counter's retention.
module ptp_rtc_adjuster
  import ptp_rtc_adjuster_pkg::*;
#(
  parameter logic [31:0] TICK_DEFAULT = 32'h1999_9999,
  parameter logic [31:0] SET_COMP_NS  = 32'd0,
  parameter int unsigned GUARD_CYC    = 8
) (
  input  logic        rtc_clk,
  input  logic        rtc_rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_type_i,
  input  logic [47:0] req_sc_i,
  input  logic [31:0] req_ns_i,
  input  logic [31:0] req_tick_i,
  input  logic [79:0] rtc_std_i,
  output logic [31:0] tick_inc_o,
  output logic [31:0] ns_offset_o,
  output logic [47:0] sc_offset_o,
  output logic        offset_valid_o,
  output logic        clear_rtc_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StCalc  = 3'd1;
  localparam logic [2:0] StNorm  = 3'd2;
  localparam logic [2:0] StIssue = 3'd3;
  localparam logic [2:0] StGuard = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  // GUARD plus the DONE cycle together cover GUARD_CYC cycles after the pulse.
  localparam logic [7:0] GuardLast = 8'(GUARD_CYC - 2);

  logic [2:0]  state_q, state_d;
  adj_req_t    req_q, req_d;
  logic [33:0] calc_ns_q, calc_ns_d;
  logic [47:0] calc_sc_q, calc_sc_d;
  logic [7:0]  guard_cnt_q, guard_cnt_d;
  logic        err_pend_q, err_pend_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] ns_off_q, ns_off_d;
  logic [47:0] sc_off_q, sc_off_d;
  logic        offset_valid_q, offset_valid_d;
  logic        clear_q, clear_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] norm_ns;
  logic [47:0] norm_sc;

  ptp_offset_norm u_norm (
    .ns_d (calc_ns_q),
    .sc_d (calc_sc_q),
    .ns_o (norm_ns),
    .sc_o (norm_sc)
  );

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    calc_ns_d      = calc_ns_q;
    calc_sc_d      = calc_sc_q;
    guard_cnt_d    = guard_cnt_q;
    err_pend_d     = err_pend_q;
    tick_d         = tick_q;
    ns_off_d       = ns_off_q;
    sc_off_d       = sc_off_q;
    offset_valid_d = 1'b0;
    clear_d        = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          req_d      = '{kind: req_type_i, sc: req_sc_i, ns: req_ns_i};
          err_pend_d = 1'b0;
          if (req_type_i == REQ_TICK) begin
            tick_d  = req_tick_i;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        state_d = StNorm;
        if (ns_out_of_range(req_q.kind, req_q.ns)) begin
          err_pend_d = 1'b1;
          state_d    = StDone;
        end else if (req_q.kind == REQ_SET) begin
          calc_ns_d = {2'b00, req_q.ns} - {2'b00, rtc_std_i[31:0]} - {2'b00, SET_COMP_NS};
          calc_sc_d = req_q.sc - rtc_std_i[79:32];
        end else if (req_q.kind == REQ_STEP) begin
          calc_ns_d = {{2{req_q.ns[31]}}, req_q.ns};
          calc_sc_d = req_q.sc;
        end
      end
      StNorm: begin
        if (req_q.kind == REQ_CLEAR) begin
          clear_d = 1'b1;
        end else begin
          offset_valid_d = 1'b1;
          ns_off_d       = norm_ns;
          sc_off_d       = norm_sc;
        end
        guard_cnt_d = '0;
        state_d     = StIssue;
      end
      StIssue: state_d = StGuard;
      StGuard: begin
        if (guard_cnt_q == GuardLast) begin
          state_d = StDone;
        end else begin
          guard_cnt_d = guard_cnt_q + 8'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        err_d   = err_pend_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge rtc_clk) begin
    if (!rtc_rst_n) begin
      state_q        <= StIdle;
      req_q          <= '0;
      calc_ns_q      <= '0;
      calc_sc_q      <= '0;
      guard_cnt_q    <= '0;
      err_pend_q     <= 1'b0;
      tick_q         <= TICK_DEFAULT;
      ns_off_q       <= '0;
      sc_off_q       <= '0;
      offset_valid_q <= 1'b0;
      clear_q        <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      calc_ns_q      <= calc_ns_d;
      calc_sc_q      <= calc_sc_d;
      guard_cnt_q    <= guard_cnt_d;
      err_pend_q     <= err_pend_d;
      tick_q         <= tick_d;
      ns_off_q       <= ns_off_d;
      sc_off_q       <= sc_off_d;
      offset_valid_q <= offset_valid_d;
      clear_q        <= clear_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign tick_inc_o     = tick_q;
  assign ns_offset_o    = ns_off_q;
  assign sc_offset_o    = sc_off_q;
  assign offset_valid_o = offset_valid_q;
  assign clear_rtc_o    = clear_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ptp_rtc_adjuster.sv
// Bench for ptp_rtc_adjuster: two instances (set-compensation 0 and 1) share one stimulus and are
// checked every cycle against a transaction-level timing/value model plus literal spot checks.
module tb_ptp_rtc_adjuster;
  localparam int unsigned G = 8;
  localparam logic [31:0] TickDef = 32'h1999_9999;
  localparam longint NsPerSec = 64'd1_000_000_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_type = 2'd0;
  logic [47:0] req_sc = '0;
  logic [31:0] req_ns = '0;
  logic [31:0] req_tick = '0;
  logic [79:0] rtc_std = '0;

  logic [1:0]        ready_w, ov_w, clr_w, done_w, err_w;
  logic [1:0][31:0]  tick_w, ns_w;
  logic [1:0][47:0]  sc_w;

  ptp_rtc_adjuster #(.TICK_DEFAULT(TickDef), .SET_COMP_NS(32'd0), .GUARD_CYC(G)) u_dut0 (
    .rtc_clk(clk), .rtc_rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_w[0]),
    .req_type_i(req_type), .req_sc_i(req_sc), .req_ns_i(req_ns), .req_tick_i(req_tick),
    .rtc_std_i(rtc_std), .tick_inc_o(tick_w[0]), .ns_offset_o(ns_w[0]), .sc_offset_o(sc_w[0]),
    .offset_valid_o(ov_w[0]), .clear_rtc_o(clr_w[0]), .done_o(done_w[0]), .err_o(err_w[0])
  );

  ptp_rtc_adjuster #(.TICK_DEFAULT(TickDef), .SET_COMP_NS(32'd1), .GUARD_CYC(G)) u_dut1 (
    .rtc_clk(clk), .rtc_rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(ready_w[1]),
    .req_type_i(req_type), .req_sc_i(req_sc), .req_ns_i(req_ns), .req_tick_i(req_tick),
    .rtc_std_i(rtc_std), .tick_inc_o(tick_w[1]), .ns_offset_o(ns_w[1]), .sc_offset_o(sc_w[1]),
    .offset_valid_o(ov_w[1]), .clear_rtc_o(clr_w[1]), .done_o(done_w[1]), .err_o(err_w[1])
  );

  // Model: one outstanding transaction with its scheduled pulse/done/commit cycles.
  int unsigned cyc;
  bit          pend;
  int unsigned acc_c, pulse_c, done_c, apply_c;
  bit          p_off, p_clr, p_err;
  logic [31:0] m_tick, n_tick;
  logic [31:0] m_ns [2];
  logic [31:0] n_ns [2];
  logic [47:0] m_sc [2];
  logic [47:0] n_sc [2];

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned last_done = 0;
  bit          last_err = 1'b0;
  int          ov_cnt = 0;
  int          clr_cnt = 0;

  function automatic bit exp_ready(input int unsigned c);
    return !(pend && c > acc_c && c < done_c);
  endfunction

  task automatic m_reset();
    m_tick = TickDef;
    n_tick = TickDef;
    for (int k = 0; k < 2; k++) begin
      m_ns[k] = '0; n_ns[k] = '0; m_sc[k] = '0; n_sc[k] = '0;
    end
  endtask

  task automatic m_accept(input int unsigned c);
    longint      nsd;
    logic [47:0] scd;
    int          s;
    pend = 1'b1; acc_c = c; p_off = 1'b0; p_clr = 1'b0; p_err = 1'b0;
    n_tick = m_tick;
    for (int k = 0; k < 2; k++) begin
      n_ns[k] = m_ns[k]; n_sc[k] = m_sc[k];
    end
    apply_c = c + 3; pulse_c = c + 3; done_c = c + 4 + G;
    case (req_type)
      2'd3: begin
        n_tick = req_tick; apply_c = c + 1; done_c = c + 2;
      end
      2'd2: p_clr = 1'b1;
      2'd0: begin
        s = $signed(req_ns);
        if (longint'(s) >= NsPerSec || longint'(s) <= -NsPerSec) begin
          p_err = 1'b1; done_c = c + 3;
        end else begin
          p_off = 1'b1;
          for (int k = 0; k < 2; k++) begin
            n_ns[k] = req_ns; n_sc[k] = req_sc;
          end
        end
      end
      default: begin
        if (longint'(req_ns) >= NsPerSec) begin
          p_err = 1'b1; done_c = c + 3;
        end else begin
          p_off = 1'b1;
          for (int k = 0; k < 2; k++) begin
            nsd = longint'(req_ns) - longint'(rtc_std[31:0]) - longint'(k);
            scd = req_sc - rtc_std[79:32];
            if (nsd <= -NsPerSec) begin
              nsd = nsd + NsPerSec; scd = scd - 48'd1;
            end else if (nsd >= NsPerSec) begin
              nsd = nsd - NsPerSec; scd = scd + 48'd1;
            end
            n_ns[k] = nsd[31:0]; n_sc[k] = scd;
          end
        end
      end
    endcase
  endtask

  initial begin
    cyc = 0; pend = 1'b0; m_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend = 1'b0; m_reset();
      end else if (req_valid && exp_ready(cyc)) begin
        m_accept(cyc);
      end
      cyc++;
      if (pend && cyc == apply_c) begin
        m_tick = n_tick;
        for (int k = 0; k < 2; k++) begin
          m_ns[k] = n_ns[k]; m_sc[k] = n_sc[k];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare both instances against the model.
  task automatic step();
    bit e_ov, e_clr, e_done;
    @(negedge clk);
    e_ov   = pend && p_off && (cyc == pulse_c);
    e_clr  = pend && p_clr && (cyc == pulse_c);
    e_done = pend && (cyc == done_c);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("c%0d u%0d ready", cyc, k), 80'(ready_w[k]), 80'(exp_ready(cyc)));
      chk($sformatf("c%0d u%0d tick", cyc, k), 80'(tick_w[k]), 80'(m_tick));
      chk($sformatf("c%0d u%0d ns_off", cyc, k), 80'(ns_w[k]), 80'(m_ns[k]));
      chk($sformatf("c%0d u%0d sc_off", cyc, k), 80'(sc_w[k]), 80'(m_sc[k]));
      chk($sformatf("c%0d u%0d offset_valid", cyc, k), 80'(ov_w[k]), 80'(e_ov));
      chk($sformatf("c%0d u%0d clear", cyc, k), 80'(clr_w[k]), 80'(e_clr));
      chk($sformatf("c%0d u%0d done", cyc, k), 80'(done_w[k]), 80'(e_done));
      if (e_done) chk($sformatf("c%0d u%0d err", cyc, k), 80'(err_w[k]), 80'(p_err));
    end
    if (done_w[0]) begin
      last_done = cyc; last_err = err_w[0];
    end
    if (ov_w[0]) ov_cnt++;
    if (clr_w[0]) clr_cnt++;
  endtask

  task automatic send(input logic [1:0] t, input logic [47:0] sc, input logic [31:0] ns,
                      input logic [31:0] tick, output int unsigned acc);
    bit got;
    @(posedge clk); #1;
    req_type = t; req_sc = sc; req_ns = ns; req_tick = tick; req_valid = 1'b1;
    got = 1'b0; acc = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (exp_ready(cyc)) begin
        acc = cyc; got = 1'b1; break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout: actual=not accepted required=accepted within 64 cycles");
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      step();
      if (!pend || cyc > done_c) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int unsigned a, a2;
  int          ov0, clr0;
  int unsigned done0;
  logic [31:0] e32;

  initial begin
    @(posedge clk); #1;
    step();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("rst_ready", 80'(ready_w[0]), 80'd1);
    chk("rst_tick", 80'(tick_w[0]), 80'h1999_9999);
    chk("rst_ns", 80'(ns_w[0]), 80'd0);
    chk("rst_done", 80'(done_w[0]), 80'd0);

    // Set tick increment.
    send(2'd3, 48'd0, 32'd0, 32'h1000_0000, a);
    step();
    chk("t1_tick", 80'(tick_w[0]), 80'h1000_0000);
    wait_done();
    chk("t1_lat", 80'(last_done - a), 80'd2);
    chk("t1_err", 80'(last_err), 80'd0);

    // Step offset sc=5 ns=-300.
    ov0 = ov_cnt;
    e32 = -32'sd300;
    send(2'd0, 48'd5, e32, 32'd0, a);
    wait_done();
    chk("t2_ns", 80'(ns_w[0]), 80'(e32));
    chk("t2_sc", 80'(sc_w[0]), 80'd5);
    chk("t2_lat", 80'(last_done - a), 80'd12);
    chk("t2_pulses", 80'(ov_cnt - ov0), 80'd1);

    // Absolute set variants.
    rtc_std = {48'd3, 32'd999_999_900};
    send(2'd1, 48'd10, 32'd100, 32'd0, a);
    wait_done();
    e32 = -32'sd999_999_800;
    chk("t3a_ns", 80'(ns_w[0]), 80'(e32));
    chk("t3a_sc", 80'(sc_w[0]), 80'd7);
    rtc_std = {48'd3, 32'd999_999_000};
    send(2'd1, 48'd10, 32'd100, 32'd0, a);
    wait_done();
    e32 = -32'sd999_998_900;
    chk("t3b_ns", 80'(ns_w[0]), 80'(e32));
    chk("t3b_sc", 80'(sc_w[0]), 80'd7);
    rtc_std = {48'd3, 32'd999_999_999};
    send(2'd1, 48'd10, 32'd0, 32'd0, a);
    wait_done();
    chk("t3c_ns_comp1", 80'(ns_w[1]), 80'd0);
    chk("t3c_sc_comp1", 80'(sc_w[1]), 80'd6);
    e32 = -32'sd999_999_999;
    chk("t3c_ns_comp0", 80'(ns_w[0]), 80'(e32));
    chk("t3c_sc_comp0", 80'(sc_w[0]), 80'd7);

    // Out-of-range requests retire with an error and no pulse.
    ov0 = ov_cnt;
    send(2'd0, 48'd1, 32'd1_000_000_000, 32'd0, a);
    wait_done();
    chk("t4_err", 80'(last_err), 80'd1);
    chk("t4_lat", 80'(last_done - a), 80'd3);
    chk("t4_ns_kept", 80'(ns_w[0]), 80'(e32));
    e32 = -32'sd1_000_000_000;
    send(2'd0, 48'd1, e32, 32'd0, a);
    wait_done();
    chk("t4n_err", 80'(last_err), 80'd1);
    send(2'd1, 48'd1, 32'd1_000_000_000, 32'd0, a);
    wait_done();
    chk("t4s_err", 80'(last_err), 80'd1);
    chk("t4_no_pulse", 80'(ov_cnt - ov0), 80'd0);
    send(2'd0, 48'd2, 32'd999_999_999, 32'd0, a);
    wait_done();
    chk("t4e_ns", 80'(ns_w[0]), 80'd999_999_999);

    // Clear, with a second request raised during the guard window.
    clr0 = clr_cnt;
    send(2'd2, 48'd0, 32'd0, 32'd0, a);
    repeat (5) step();
    send(2'd3, 48'd0, 32'd0, TickDef, a2);
    chk("t5_clear_pulses", 80'(clr_cnt - clr0), 80'd1);
    chk("t5_accept_gap", 80'(a2 - a), 80'd12);
    chk("t5_accept_at_done", 80'(last_done), 80'(a2));
    wait_done();
    chk("t5_tick", 80'(tick_w[0]), 80'(TickDef));

    // Reset during GUARD.
    send(2'd0, 48'd1, 32'd50, 32'd0, a);
    while (cyc < a + 5) step();
    @(posedge clk); #1;
    rst_n = 1'b0;
    step();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("t6g_ready", 80'(ready_w[0]), 80'd1);
    chk("t6g_ns", 80'(ns_w[0]), 80'd0);
    chk("t6g_sc", 80'(sc_w[0]), 80'd0);
    ov0 = ov_cnt; done0 = last_done;
    repeat (15) step();
    chk("t6g_no_pulse", 80'(ov_cnt - ov0), 80'd0);
    chk("t6g_no_done", 80'(last_done), 80'(done0));

    // Reset during CALC.
    send(2'd0, 48'd4, 32'd70, 32'd0, a);
    rst_n = 1'b0;
    step();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("t6c_ready", 80'(ready_w[0]), 80'd1);
    chk("t6c_tick", 80'(tick_w[0]), 80'(TickDef));
    ov0 = ov_cnt; done0 = last_done;
    repeat (15) step();
    chk("t6c_no_pulse", 80'(ov_cnt - ov0), 80'd0);
    chk("t6c_no_done", 80'(last_done), 80'(done0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
